// File: rtl/link_pkg.sv
// -----------------------------------------------------------------------------
// link_pkg
// Shared types and constants for the remote command link endpoint.
//   framer_state_e : command framer states (HIGH byte expected / LOW byte expected)
//   tx_state_e     : response transmitter states (IDLE / XMIT)
//   RESP_POS_ACK   : positive acknowledge response byte
//   CMD_BYTES      : bytes per command frame
//   pack_cmd()     : assembles a command word, high byte first on the wire
// -----------------------------------------------------------------------------
package link_pkg;

  typedef enum logic {
    HIGH,
    LOW
  } framer_state_e;

  typedef enum logic {
    IDLE,
    XMIT
  } tx_state_e;

  localparam logic [7:0] RESP_POS_ACK = 8'hA5;
  localparam int         CMD_BYTES    = 2;
  localparam int         CMD_W        = 8 * CMD_BYTES;

  function automatic logic [CMD_W-1:0] pack_cmd(input logic [7:0] hi_byte,
                                                input logic [7:0] lo_byte);
    return {hi_byte, lo_byte};
  endfunction

endpackage

// File: rtl/link_byte_uart.sv
// -----------------------------------------------------------------------------
// link_byte_uart
// Bit-level 8N1 deserializer and serializer with independent baud counters.
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   rx        in   asynchronous serial input, idle high
//   tx        out  serial output, idle high (registered)
//   rx_byte   out  last received data byte
//   rx_rdy    out  1-cycle strobe: stop bit sampled high, rx_byte valid
//   rx_ferr   out  1-cycle strobe: stop bit sampled low, byte discarded
//   rx_busy   out  receiver is inside a frame (start edge seen)
//   tx_byte   in   byte to transmit, taken when tx_start is accepted
//   tx_start  in   start request; accepted when idle or on the last frame cycle
//   tx_done   out  high on the last cycle of each transmitted stop bit
// -----------------------------------------------------------------------------
module link_byte_uart #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] rx_byte,
  output logic       rx_rdy,
  output logic       rx_ferr,
  output logic       rx_busy,
  input  logic [7:0] tx_byte,
  input  logic       tx_start,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic             r_rx_s1;
  logic             r_rx_s2;
  logic             r_rx_prev;
  rx_state_e        r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             w_rx_stop_smp;

  // NOTE: every clocked register is written with <= so all flops update
  // together from pre-edge values; blocking = here would create order-dependent
  // shift and counter behaviour that no longer matches the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_s2) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= HALF_M1;
          end
        end
        RX_START: begin
          if (r_rx_cnt == '0) begin
            // A start bit that is high again at mid-bit was a glitch.
            if (!r_rx_s2) begin
              r_rx_state <= RX_DATA;
              r_rx_cnt   <= FULL_M1;
              r_rx_bit   <= '0;
            end else begin
              r_rx_state <= RX_IDLE;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == '0) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_cnt   <= FULL_M1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_bit   <= r_rx_bit + 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        RX_STOP: begin
          // Returning to idle at mid-stop lets a back-to-back start edge,
          // half a bit later, be caught.
          if (r_rx_cnt == '0) r_rx_state <= RX_IDLE;
          else                r_rx_cnt   <= r_rx_cnt - 1'b1;
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign w_rx_stop_smp = (r_rx_state == RX_STOP) && (r_rx_cnt == '0);
  assign rx_rdy        = w_rx_stop_smp && r_rx_s2;
  assign rx_ferr       = w_rx_stop_smp && !r_rx_s2;
  assign rx_byte       = r_rx_shift;
  assign rx_busy       = (r_rx_state != RX_IDLE);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  logic             r_tx;
  logic             r_tx_act;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [3:0]       r_tx_bit;
  logic [8:0]       r_tx_shift;   // {stop, data[7:0]}; start bit driven on load
  logic             w_tx_last;

  assign w_tx_last = r_tx_act && (r_tx_bit == 4'd9) && (r_tx_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx       <= 1'b1;
      r_tx_act   <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '1;
    end else if (tx_start && (!r_tx_act || w_tx_last)) begin
      // Loading on the last stop cycle makes consecutive frames gapless.
      r_tx       <= 1'b0;
      r_tx_act   <= 1'b1;
      r_tx_cnt   <= FULL_M1;
      r_tx_bit   <= '0;
      r_tx_shift <= {1'b1, tx_byte};
    end else if (r_tx_act) begin
      if (r_tx_cnt == '0) begin
        if (r_tx_bit == 4'd9) begin
          r_tx_act <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_tx       <= r_tx_shift[0];
          r_tx_shift <= {1'b1, r_tx_shift[8:1]};
          r_tx_bit   <= r_tx_bit + 1'b1;
          r_tx_cnt   <= FULL_M1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt - 1'b1;
      end
    end
  end

  assign tx      = r_tx;
  assign tx_done = w_tx_last;

endmodule

// File: rtl/cmd_link_responder.sv
// -----------------------------------------------------------------------------
// cmd_link_responder
// Knight-side endpoint of the remote command link. Frames received UART bytes
// into 16-bit commands (high byte first) and serializes 1-byte responses with a
// one-entry pending buffer.
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   RX           in   serial in, asynchronous, idle high
//   TX           out  serial out, idle high
//   cmd          out  last complete command {high, low}
//   cmd_rdy      out  level: a new cmd is valid
//   clr_cmd_rdy  in   consumer acknowledge, clears cmd_rdy (a same-cycle set wins)
//   resp         in   response byte, sampled with send_resp
//   send_resp    in   1-cycle request to transmit resp
//   tx_busy      out  transmitter busy, held across a pending byte
//   resp_sent    out  1-cycle pulse at the end of each stop bit
//   resp_ovfl    out  1-cycle pulse when a response is dropped
//   frm_err      out  1-cycle pulse on a bad stop bit or inter-byte timeout
// Build option: define CMD_LINK_BYTE_TIMEOUT_EN to abandon a half-received
// command when no start edge follows the high byte within TIMEOUT_BITS bit times.
// -----------------------------------------------------------------------------
module cmd_link_responder
  import link_pkg::*;
#(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RX,
  output logic             TX,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic [7:0]       resp,
  input  logic             send_resp,
  output logic             tx_busy,
  output logic             resp_sent,
  output logic             resp_ovfl,
  output logic             frm_err
);

  logic [7:0] w_rx_byte;
  logic       w_rx_rdy;
  logic       w_rx_ferr;
  logic       w_rx_busy;
  logic [7:0] w_tx_byte;
  logic       w_tx_start;
  logic       w_tx_done;
  logic       w_timeout;

  link_byte_uart #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart (
    .clk      (clk),
    .rst      (rst),
    .rx       (RX),
    .tx       (TX),
    .rx_byte  (w_rx_byte),
    .rx_rdy   (w_rx_rdy),
    .rx_ferr  (w_rx_ferr),
    .rx_busy  (w_rx_busy),
    .tx_byte  (w_tx_byte),
    .tx_start (w_tx_start),
    .tx_done  (w_tx_done)
  );

  // ---------------------------------------------------------------------------
  // Command framer
  // ---------------------------------------------------------------------------
  framer_state_e    r_fr_state;
  logic [7:0]       r_hi_byte;
  logic [CMD_W-1:0] r_cmd;
  logic             r_cmd_rdy;
  logic             r_frm_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fr_state <= HIGH;
      r_hi_byte  <= '0;
      r_cmd      <= '0;
      r_cmd_rdy  <= 1'b0;
      r_frm_err  <= 1'b0;
    end else begin
      r_frm_err <= w_rx_ferr || w_timeout;
      if (w_rx_ferr || w_timeout) begin
        r_fr_state <= HIGH;
        if (clr_cmd_rdy) r_cmd_rdy <= 1'b0;
      end else if (w_rx_rdy && (r_fr_state == HIGH)) begin
        r_hi_byte  <= w_rx_byte;
        r_cmd_rdy  <= 1'b0;
        r_fr_state <= LOW;
      end else if (w_rx_rdy && (r_fr_state == LOW)) begin
        r_cmd      <= pack_cmd(r_hi_byte, w_rx_byte);
        r_cmd_rdy  <= 1'b1;
        r_fr_state <= HIGH;
      end else if (clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
    end
  end

`ifdef CMD_LINK_BYTE_TIMEOUT_EN
  localparam int TO_CYCLES = TIMEOUT_BITS * BAUD_DIV;
  localparam int TO_W      = $clog2(TO_CYCLES);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_to_halt;

  // Counts from the high byte's stop sample; once a start edge is seen the
  // low byte owns the outcome, so the counter freezes until LOW is left.
  always_ff @(posedge clk) begin
    if (rst || (r_fr_state != LOW)) begin
      r_to_cnt  <= '0;
      r_to_halt <= 1'b0;
    end else if (w_rx_busy) begin
      r_to_halt <= 1'b1;
    end else if (!r_to_halt) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_fr_state == LOW) && !r_to_halt && !w_rx_busy &&
                     (r_to_cnt == TO_W'(TO_CYCLES - 1));
`else
  logic w_unused_timeout_bits;

  // TIMEOUT_BITS stays on the interface so both builds share one port map.
  assign w_unused_timeout_bits = ^TIMEOUT_BITS;
  assign w_timeout             = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Response transmit control with one-entry pending buffer
  // ---------------------------------------------------------------------------
  tx_state_e  r_tx_state;
  logic       r_pend_vld;
  logic [7:0] r_pend_byte;
  logic       r_resp_ovfl;
  logic       w_direct;
  logic       w_push;
  logic       w_ovfl;
  logic       w_pend_pop;

  // NOTE: each output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_direct   = 1'b0;
    w_push     = 1'b0;
    w_ovfl     = 1'b0;
    w_pend_pop = w_tx_done && r_pend_vld;
    w_tx_byte  = resp;
    if (send_resp) begin
      // On the last stop cycle an empty buffer is bypassed, and a full one is
      // being drained, so neither case drops the new request.
      if ((r_tx_state == IDLE) || (w_tx_done && !r_pend_vld)) w_direct = 1'b1;
      else if (!r_pend_vld || w_pend_pop)                      w_push   = 1'b1;
      else                                                     w_ovfl   = 1'b1;
    end
    if (w_pend_pop) w_tx_byte = r_pend_byte;
    w_tx_start = w_direct || w_pend_pop;
  end

  // NOTE: the pending data byte is reset along with its valid flag even though
  // only the flag matters functionally; the storage is one byte, and a known
  // value keeps reset behaviour fully deterministic.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state  <= IDLE;
      r_pend_vld  <= 1'b0;
      r_pend_byte <= '0;
      r_resp_ovfl <= 1'b0;
    end else begin
      r_resp_ovfl <= w_ovfl;
      if (w_tx_start)     r_tx_state <= XMIT;
      else if (w_tx_done) r_tx_state <= IDLE;
      if (w_push) begin
        r_pend_vld  <= 1'b1;
        r_pend_byte <= resp;
      end else if (w_pend_pop) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign cmd       = r_cmd;
  assign cmd_rdy   = r_cmd_rdy;
  assign frm_err   = r_frm_err;
  assign tx_busy   = (r_tx_state == XMIT);
  assign resp_sent = w_tx_done;
  assign resp_ovfl = r_resp_ovfl;

endmodule

// File: tb/tb_cmd_link_responder.sv
module tb_cmd_link_responder;
  import link_pkg::*;

  localparam int B = 16;

  logic        clk;
  logic        rst;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        tx_busy;
  logic        resp_sent;
  logic        resp_ovfl;
  logic        frm_err;

  cmd_link_responder #(
    .BAUD_DIV     (B),
    .TIMEOUT_BITS (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .tx_busy     (tx_busy),
    .resp_sent   (resp_sent),
    .resp_ovfl   (resp_ovfl),
    .frm_err     (frm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards: expectations pushed as stimulus is driven, popped by monitors.
  logic [15:0] cmd_q[$];
  logic [7:0]  tx_q[$];

  int frm_err_cnt = 0;
  int ovfl_cnt    = 0;
  int sent_cnt    = 0;

  // Command monitor: compares cmd on every rising edge of cmd_rdy.
  logic prev_cmd_rdy = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (frm_err)   frm_err_cnt++;
      if (resp_ovfl) ovfl_cnt++;
      if (resp_sent) sent_cnt++;
      if (cmd_rdy === 1'b1 && prev_cmd_rdy !== 1'b1) begin
        if (cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected: got %0h expected none", cmd);
        end else begin
          check("cmd_value", cmd, cmd_q.pop_front());
        end
      end
    end
    prev_cmd_rdy = cmd_rdy;
  end

  // TX monitor: decodes frames at mid-bit, checks stop bit, byte and the
  // position of resp_sent (last cycle of the 10*B-cycle frame).
  bit         mon_act = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte;
  always @(negedge clk) begin
    bit at_end;
    if (rst) begin
      mon_act = 1'b0;
    end else begin
      if (!mon_act) begin
        if (TX === 1'b0) begin
          mon_act = 1'b1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
      end
      at_end = mon_act && (mon_cnt == 10 * B - 1);
      if (resp_sent === 1'b1 && !at_end) begin
        checks++;
        errors++;
        $display("FAIL resp_sent_position: got pulse at frame cycle %0d expected %0d", mon_cnt, 10 * B - 1);
      end
      if (mon_act && (mon_cnt % B == B / 2)) begin
        if (mon_cnt / B >= 1 && mon_cnt / B <= 8) mon_byte[mon_cnt / B - 1] = TX;
        if (mon_cnt / B == 9) begin
          check("tx_stop_bit", TX, 1);
          if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected: got byte %0h expected none", mon_byte);
          end else begin
            check("tx_byte", mon_byte, tx_q.pop_front());
          end
        end
      end
      if (at_end) begin
        check("resp_sent_at_end", resp_sent, 1);
        mon_act = 1'b0;
      end
    end
  end

  // Watchdog: the run must always end on its own.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (B) @(negedge clk);
    end
    RX = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
  endtask

  task automatic pulse_resp(input logic [7:0] b, input bit expect_sent);
    resp      = b;
    send_resp = 1'b1;
    if (expect_sent) tx_q.push_back(b);
    @(negedge clk);
    send_resp = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp_cmd;
  } cmd_vec_t;

  cmd_vec_t vecs[4];

  initial begin
    logic [9:0] ack_frame;
    int fe0;
    int oc0;
    int sc0;

    vecs[0] = '{hi: 8'h40, lo: 8'h04, exp_cmd: 16'h4004};
    vecs[1] = '{hi: 8'hFF, lo: 8'h00, exp_cmd: 16'hFF00};
    vecs[2] = '{hi: 8'h00, lo: 8'hFF, exp_cmd: 16'h00FF};
    vecs[3] = '{hi: 8'hA5, lo: 8'h5A, exp_cmd: 16'hA55A};

    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; resp = '0; send_resp = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_TX", TX, 1);
    check("rst_cmd", cmd, 16'h0000);
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_pulses", {resp_sent, resp_ovfl, frm_err}, 3'b000);

    // Command receive, back-to-back bytes; first vector also checks latency:
    // cmd_rdy rises 155 cycles after the low byte's start bit is driven.
    for (int i = 0; i < 4; i++) begin
      cmd_q.push_back(vecs[i].exp_cmd);
      send_byte(vecs[i].hi);
      if (i == 0) begin
        fork
          send_byte(vecs[i].lo);
          begin
            repeat (154) @(negedge clk);
            check("cmd_rdy_early", cmd_rdy, 0);
            @(negedge clk);
            check("cmd_rdy_latency", cmd_rdy, 1);
          end
        join
      end else begin
        send_byte(vecs[i].lo);
      end
      repeat (2) @(negedge clk);
      check("cmd_q_drained", cmd_q.size(), 0);
      check("cmd_rdy_set", cmd_rdy, 1);
      pulse_clr();
      check("cmd_rdy_cleared", cmd_rdy, 0);
    end

    // Ack transmit: exact line levels for each bit time.
    ack_frame = {1'b1, RESP_POS_ACK, 1'b0};
    check("tx_idle_before_ack", TX, 1);
    pulse_resp(RESP_POS_ACK, 1'b1);
    check("tx_falls_next_cycle", TX, 0);
    check("tx_busy_after_accept", tx_busy, 1);
    for (int b = 0; b < 10; b++) begin
      int ok;
      ok = 0;
      for (int c = 0; c < B; c++) begin
        if (TX === ack_frame[b]) ok++;
        if (b == 9 && c == B - 2) check("resp_sent_not_early", resp_sent, 0);
        if (b == 9 && c == B - 1) check("resp_sent_160th_cycle", resp_sent, 1);
        @(negedge clk);
      end
      check($sformatf("ack_bit%0d_cycles", b), ok, B);
    end
    check("tx_busy_after_frame", tx_busy, 0);
    check("tx_q_after_ack", tx_q.size(), 0);

    // Pending buffer and overflow.
    repeat (5) @(negedge clk);
    oc0 = ovfl_cnt;
    sc0 = sent_cnt;
    pulse_resp(8'hA5, 1'b1);
    repeat (19) @(negedge clk);
    pulse_resp(8'h5A, 1'b1);
    repeat (10) @(negedge clk);
    pulse_resp(8'h33, 1'b0);
    for (int n = 0; n < 400 && resp_sent !== 1'b1; n++) @(negedge clk);
    check("first_resp_sent", resp_sent, 1);
    @(negedge clk);
    check("pending_contiguous_start", TX, 0);
    check("tx_busy_across_bytes", tx_busy, 1);
    for (int n = 0; n < 400 && tx_busy !== 1'b0; n++) @(negedge clk);
    check("tx_busy_drop", tx_busy, 0);
    repeat (2) @(negedge clk);
    check("resp_sent_twice", sent_cnt - sc0, 2);
    check("ovfl_once", ovfl_cnt - oc0, 1);
    check("tx_q_drained", tx_q.size(), 0);

    // Framing error in LOW discards the high byte.
    fe0 = frm_err_cnt;
    send_byte(8'h77);
    send_frame(8'hC3, 1'b0);
    repeat (B) @(negedge clk);
    check("frm_err_pulse", frm_err_cnt - fe0, 1);
    check("cmd_rdy_after_ferr", cmd_rdy, 0);
    cmd_q.push_back(16'h1234);
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (2) @(negedge clk);
    check("cmd_q_after_ferr", cmd_q.size(), 0);
    check("cmd_rdy_after_recover", cmd_rdy, 1);
    pulse_clr();

    // Inter-byte gap of 330 cycles after a high byte.
    fe0 = frm_err_cnt;
    send_byte(8'h40);
    repeat (330) @(negedge clk);
`ifdef CMD_LINK_BYTE_TIMEOUT_EN
    check("timeout_frm_err", frm_err_cnt - fe0, 1);
    cmd_q.push_back(16'h4004);
    send_byte(8'h40);
    send_byte(8'h04);
`else
    check("no_timeout_frm_err", frm_err_cnt - fe0, 0);
    cmd_q.push_back(16'h4004);
    send_byte(8'h04);
`endif
    repeat (2) @(negedge clk);
    check("cmd_q_after_gap", cmd_q.size(), 0);
    check("cmd_after_gap", cmd, 16'h4004);

    // Reset in the middle of a transmitted byte, with cmd_rdy still set.
    check("cmd_rdy_before_reset", cmd_rdy, 1);
    pulse_resp(RESP_POS_ACK, 1'b0);
    repeat (4 * B + B / 2 - 1) @(negedge clk);
    check("tx_busy_mid_frame", tx_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("reset_TX", TX, 1);
    check("reset_tx_busy", tx_busy, 0);
    check("reset_cmd_rdy", cmd_rdy, 0);
    check("reset_cmd", cmd, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    sc0 = sent_cnt;
    repeat (200) @(negedge clk);
    check("no_resp_sent_after_reset", sent_cnt - sc0, 0);
    check("TX_idle_after_reset", TX, 1);
    check("tx_q_final", tx_q.size(), 0);
    check("cmd_q_final", cmd_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_link_responder.md
# cmd_link_responder

Knight-side endpoint of the remote command link. Deserializes 8N1 UART bytes from the remote controller and frames them into 16-bit commands: high byte first, then low byte. Serializes 1-byte responses (e.g. positive ack 0xA5) back to the remote controller. It sits between the knight's `RX`/`TX` pins and the command processor, which consumes `cmd`/`cmd_rdy` and drives `resp`/`send_resp`.

## Interface
Parameters:
- `BAUD_DIV`, default 2604: clk cycles per bit (50 MHz / 19200 baud); legal range ≥ 8.
- `TIMEOUT_BITS`, default 20: inter-byte timeout in bit times; used only with the macro.

Ports:
- `clk`, input, 1: system clock; all logic on rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `RX`, input, 1: serial in, asynchronous, idle high.
- `TX`, output, 1: serial out, idle high.
- `cmd`, output, 16: last complete command, `{high, low}`.
- `cmd_rdy`, output, 1: level; a new `cmd` is valid.
- `clr_cmd_rdy`, input, 1: consumer acknowledge; clears `cmd_rdy`.
- `resp`, input, 8: response byte, sampled when `send_resp` is high.
- `send_resp`, input, 1: 1-cycle request to transmit `resp`.
- `tx_busy`, output, 1: high from the cycle after acceptance until the stop bit ends.
- `resp_sent`, output, 1: 1-cycle pulse at the end of each stop bit.
- `resp_ovfl`, output, 1: 1-cycle pulse when a response is dropped.
- `frm_err`, output, 1: 1-cycle pulse on a bad stop bit or an inter-byte timeout.

## Operation
- **Reset values:** `TX`=1, `cmd`=0, `cmd_rdy`=0, `tx_busy`=0, all pulses 0, framer in HIGH, pending buffer empty.
- **RX path:**
  - `RX` passes through a 2-flop synchronizer.
  - A falling edge while idle starts a byte.
  - Sampling points: start bit at BAUD_DIV/2, each data bit every BAUD_DIV after that, LSB first, then the stop bit.
  - If the start bit reads 1 at mid-sample, the byte is aborted silently and RX returns to idle.
  - If the stop bit reads 0, the byte is discarded, `frm_err` pulses, and the framer returns to HIGH.
- **Framer FSM:**
  - HIGH: a byte arrives → latch it as the high byte, clear `cmd_rdy`, go to LOW.
  - LOW: a byte arrives → `cmd` ← `{high, byte}`, set `cmd_rdy`, go to HIGH.
  - Set and clear of `cmd_rdy` in the same cycle: set wins.
- **TX path:**
  - `send_resp` while idle: latch `resp` and start the start bit next cycle.
  - `send_resp` while busy and the pending buffer is empty: latch `resp` into the 1-entry pending buffer. Its start bit begins the cycle after the current `resp_sent`, and `tx_busy` stays high across the two bytes.
  - `send_resp` while busy and the pending buffer is full: drop the byte and pulse `resp_ovfl`.
- **Reset mid-operation:** the partial frame is discarded, the pending buffer is emptied, and `TX` is forced to 1 on the cycle after `rst`.

## Timing
- `cmd_rdy` rises exactly 1 cycle after the low byte's stop-bit sample.
- `TX` falls 1 cycle after `send_resp` when idle.
- One frame on `TX` lasts 10·BAUD_DIV cycles. `resp_sent` pulses on its last cycle and `tx_busy` falls the next cycle, unless a pending byte is present.
- RX and TX are fully independent, so full-duplex operation is legal.
- Back-to-back RX bytes with zero idle between stop and start bits are accepted.

## Configuration
- Macro `CMD_LINK_BYTE_TIMEOUT_EN`.
- **Defined:**
  - In LOW, a counter measures time from the high byte's stop sample.
  - If TIMEOUT_BITS·BAUD_DIV cycles elapse with no new start edge, the high byte is discarded, `frm_err` pulses, and the FSM returns to HIGH.
  - A start edge halts the counter.
- **Undefined:** LOW waits indefinitely, and no counter logic is synthesized.

## Structure
- Shared package `link_pkg` holds:
  - the framer state enum (`HIGH`, `LOW`);
  - the TX state enum (`IDLE`, `XMIT`);
  - constants `RESP_POS_ACK` = 8'hA5 and `CMD_BYTES` = 2.
- One sub-module, `link_byte_uart`: bit-level 8N1 serializer/deserializer plus baud counters. Its outputs are `rx_byte`, `rx_rdy` and `rx_ferr`; its inputs are `tx_byte` and `tx_start`, and it outputs `tx_done`.
- The top level contains the framer FSM, the pending buffer and the timeout counter.

## Test plan
All scenarios use BAUD_DIV=16.
- **Command receive:** send bytes 0x40, 0x04 → `cmd`=16'h4004 and `cmd_rdy`=1 one cycle after the second stop sample. Pulse `clr_cmd_rdy` → `cmd_rdy`=0 next cycle.
- **Ack transmit:** `resp`=0xA5 with `send_resp` pulsed while idle → `TX` reads 0,1,0,1,0,0,1,0,1,1 for 16 cycles each. `resp_sent` pulses 160 cycles after `TX` falls.
- **Pending buffer and overflow:**
  - Send 0xA5; 20 cycles later send 0x5A → both bytes are sent contiguously and `resp_sent` pulses twice.
  - A third `send_resp` during the first byte → `resp_ovfl` pulses and the third byte is never sent.
- **Framing error:** a byte with stop bit 0 → `frm_err` pulses and `cmd_rdy` stays 0. A following valid 0x12, 0x34 pair → `cmd`=16'h1234.
- **Timeout (macro defined):** send 0x40, then idle for 330 cycles → `frm_err` pulses. Next 0x40, 0x04 → `cmd`=16'h4004.
- **Reset mid-TX:** assert `rst` at bit 4 of 0xA5 → `TX`=1, `tx_busy`=0 and `cmd_rdy`=0 the cycle after, and no `resp_sent`.
